// File: rtl/conv3x3_window_ctrl.sv
// conv3x3_window_ctrl: frame controller feeding a 3x3 convolution core.
// Latches the frame geometry, kernel weights and bias on a legal start, issues
// a one-cycle weight-load strobe, then streams raster-order pixels through two
// line buffers and a 3x3 shift window, presenting each complete window once.
`timescale 1ns/1ps
module conv3x3_window_ctrl #(
    parameter int MAX_W = 32,
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         cfg_width,
    input  logic [5:0]         cfg_height,
    input  logic [71:0]        cfg_weights,
    input  logic [7:0]         cfg_bias,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               pix_ready,
    output logic               weight_en,
    output logic [71:0]        weights_data,
    output logic [7:0]         bias_data,
    output logic               win_valid,
    output logic [9*PIX_W-1:0] win_data,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [11:0]        out_count
);

    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [6:0] MAX_W7 = 7'(MAX_W);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [5:0]         width_q, width_d;
    logic [5:0]         height_q, height_d;
    logic [71:0]        weights_q, weights_d;
    logic [7:0]         bias_q, bias_d;
    logic [5:0]         col_q, col_d;
    logic [5:0]         row_q, row_d;
    logic [11:0]        out_count_q, out_count_d;
    logic               win_valid_q, win_valid_d;
    logic               cfg_err_q, cfg_err_d;
    logic [9*PIX_W-1:0] win_q, win_d;

    // line0 holds the previous row, line1 the row before that
    logic [PIX_W-1:0]   line0_mem [MAX_W];
    logic [PIX_W-1:0]   line1_mem [MAX_W];

    logic               accept;
    logic               cfg_ok;
    logic [AW-1:0]      col_idx;
    logic [PIX_W-1:0]   top_pix;
    logic [PIX_W-1:0]   mid_pix;

    assign accept  = pix_valid && (state_q == S_STREAM);
    assign cfg_ok  = (cfg_width >= 6'd3) && ({1'b0, cfg_width} <= MAX_W7) && (cfg_height >= 6'd3);
    assign col_idx = col_q[AW-1:0];
    assign top_pix = line1_mem[col_idx];
    assign mid_pix = line0_mem[col_idx];

    // Next-state, latching, counters and window shift
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        weights_d   = weights_q;
        bias_d      = bias_q;
        col_d       = col_q;
        row_d       = row_q;
        out_count_d = out_count_q;
        win_valid_d = 1'b0;
        cfg_err_d   = 1'b0;
        win_d       = win_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        width_d     = cfg_width;
                        height_d    = cfg_height;
                        weights_d   = cfg_weights;
                        bias_d      = cfg_bias;
                        col_d       = 6'd0;
                        row_d       = 6'd0;
                        out_count_d = 12'd0;
                        state_d     = S_LOAD_W;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_LOAD_W: state_d = S_STREAM;
            S_STREAM: begin
                if (accept) begin
                    // Shift every window row left by one column, new column enters on the right
                    for (int r = 0; r < 3; r++) begin
                        win_d[(3*r)*PIX_W +: PIX_W]   = win_q[(3*r+1)*PIX_W +: PIX_W];
                        win_d[(3*r+1)*PIX_W +: PIX_W] = win_q[(3*r+2)*PIX_W +: PIX_W];
                    end
                    win_d[2*PIX_W +: PIX_W] = top_pix;
                    win_d[5*PIX_W +: PIX_W] = mid_pix;
                    win_d[8*PIX_W +: PIX_W] = pix_data;
                    // Columns 0 and 1 of each row refill the window, so no window spans a wrap
                    if ((row_q >= 6'd2) && (col_q >= 6'd2)) begin
                        win_valid_d = 1'b1;
                        out_count_d = out_count_q + 12'd1;
                    end
                    if (col_q == width_q - 6'd1) begin
                        col_d = 6'd0;
                        if (row_q == height_q - 6'd1) begin
                            row_d   = 6'd0;
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + 6'd1;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            width_q     <= 6'd0;
            height_q    <= 6'd0;
            weights_q   <= 72'd0;
            bias_q      <= 8'd0;
            col_q       <= 6'd0;
            row_q       <= 6'd0;
            out_count_q <= 12'd0;
            win_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            weights_q   <= weights_d;
            bias_q      <= bias_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_count_q <= out_count_d;
            win_valid_q <= win_valid_d;
            cfg_err_q   <= cfg_err_d;
            win_q       <= win_d;
        end
    end

    // Line buffers roll down one row per accepted pixel; contents survive reset
    always_ff @(posedge clk) begin
        if (accept) begin
            line1_mem[col_idx] <= mid_pix;
            line0_mem[col_idx] <= pix_data;
        end
    end

    assign pix_ready    = (state_q == S_STREAM);
    assign weight_en    = (state_q == S_LOAD_W);
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign weights_data = weights_q;
    assign bias_data    = bias_q;
    assign win_valid    = win_valid_q;
    assign win_data     = win_q;
    assign cfg_err      = cfg_err_q;
    assign out_count    = out_count_q;

endmodule

// File: doc/conv3x3_window_ctrl.md
CONV3X3_WINDOW_CTRL -- requirements
Module: conv3x3_window_ctrl

Interface
REQ-001 SHALL have parameter MAX_W, default 32: maximum image width, which is also the line-buffer depth.
REQ-002 SHALL have parameter PIX_W, default 8: pixel width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle frame start request.
REQ-006 SHALL have port cfg_width  input  6  image width W; legal range 3..MAX_W.
REQ-007 SHALL have port cfg_height  input  6  image height H; legal range 3..63.
REQ-008 SHALL have port cfg_weights  input  72  nine signed 8-bit kernel weights, w0 at [71:64] through w8 at [7:0].
REQ-009 SHALL have port cfg_bias  input  8  signed kernel bias.
REQ-010 SHALL have port pix_valid  input  1  raster-order pixel present.
REQ-011 SHALL have port pix_data  input  PIX_W  pixel value.
REQ-012 SHALL have port pix_ready  output  1  pixel accept enable.
REQ-013 SHALL have port weight_en  output  1  one-cycle weight-load strobe to conv3x3.
REQ-014 SHALL have port weights_data  output  72  latched weights to conv3x3.
REQ-015 SHALL have port bias_data  output  8  latched bias to conv3x3.
REQ-016 SHALL have port win_valid  output  1  drives conv3x3 data_in_valid.
REQ-017 SHALL have port win_data  output  9*PIX_W  window; byte k (bits [8k+7:8k]) drives data_in_k, with k=0 top-left, row-major.
REQ-018 SHALL have ports busy  output  1, done  output  1 (pulse), cfg_err  output  1 (pulse), out_count  output  12.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD_W, STREAM and DONE.
REQ-020 In IDLE, start with legal cfg SHALL latch W, H, weights and bias, clear out_count, and transition to LOAD_W.
REQ-021 In IDLE, start with illegal cfg SHALL pulse cfg_err for 1 cycle (next cycle), stay in IDLE, and leave all latched values unchanged.
REQ-022 start outside IDLE SHALL be ignored, with no cfg_err.
REQ-023 LOAD_W SHALL last exactly 1 cycle with weight_en=1, then transition to STREAM; weight_en SHALL be 0 in all other states.
REQ-024 weights_data and bias_data SHALL continuously present the latched values in every state.
REQ-025 pix_ready SHALL be 1 only in STREAM; a pixel is accepted when pix_valid && pix_ready.
REQ-026 The column counter (col) SHALL increment on each accept and wrap from W-1 to 0, incrementing row on wrap; when pix_valid=0 it SHALL hold with no time-out.
REQ-027 SHALL keep two row line buffers of MAX_W entries plus a 3x3 shift window, so no pixel is ever re-requested.
REQ-028 Accepting the pixel at (row,col) with row>=2 and col>=2 SHALL register win_valid=1 on the next cycle, with win_data = pixels rows row-2..row, cols col-2..col; otherwise win_valid SHALL be 0 on the next cycle.
REQ-029 Windows SHALL never span a row wrap: the first window of each row is at col=2.
REQ-030 out_count SHALL increment on each win_valid and reach (W-2)*(H-2) at frame end; it SHALL hold until the next accepted start.
REQ-031 Accepting the pixel at (H-1,W-1) SHALL transition to DONE.
REQ-032 DONE SHALL assert done=1 for 1 cycle, coincident with the final win_valid, then transition to IDLE.
REQ-033 busy SHALL equal (state != IDLE).

Reset
REQ-034 rst SHALL force, immediately and asynchronously: state=IDLE, pix_ready=0, weight_en=0, win_valid=0, done=0, cfg_err=0, busy=0, out_count=0, row/col=0, weights_data=0, bias_data=0, win_data=0.
REQ-035 Line-buffer contents need not be cleared on rst.
REQ-036 rst mid-frame SHALL abandon the frame; the next start SHALL run a complete fresh frame with no stale window emitted.

Verification
REQ-037 Scenario: W=H=5, pixels 1..25 streamed continuously, weights 01_01_01_01_02_01_01_01_01 -> weight_en for 1 cycle; 9 win_valid pulses; first window 1,2,3,6,7,8,11,12,13; last window 13,14,15,18,19,20,23,24,25; done with 9th; out_count=9.
REQ-038 Scenario: same frame with pix_valid deasserted on alternate cycles -> identical 9 windows in the same order; no win_valid during gaps.
REQ-039 Scenario: start with W=2, then with H=2, then with W=MAX_W+1 -> cfg_err pulse each time; busy stays 0; weight_en never asserts.
REQ-040 Scenario: W=32, H=3 -> 30 windows; first window contains pixels at cols 0..2 of rows 0..2; done with 30th window.
REQ-041 Scenario: rst asserted after 12 pixels of a 5x5 frame -> all outputs reset at once; restart streaming 1..25 -> the same 9 windows as the first scenario.
REQ-042 Scenario: start pulsed mid-STREAM -> ignored; frame completes normally; out_count=9.
